// File: rtl/multi_stamper_pkg.sv
// Width derivations and field layout of the timestamper event word:
// {valid, ovf, ch_id[CH_W], timestamp[CNT_WIDTH]}.
package multi_stamper_pkg;
  localparam int TS_LSB = 0;

  function automatic int calc_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int calc_word_w(input int num_ch, input int cnt_w);
    return 2 + calc_ch_w(num_ch) + cnt_w;
  endfunction

  function automatic int ch_lsb(input int cnt_w);
    return TS_LSB + cnt_w;
  endfunction

  function automatic int ovf_bit(input int num_ch, input int cnt_w);
    return ch_lsb(cnt_w) + calc_ch_w(num_ch);
  endfunction

  function automatic int valid_bit(input int num_ch, input int cnt_w);
    return ovf_bit(num_ch, cnt_w) + 1;
  endfunction
endpackage

// File: rtl/stamp_fifo.sv
// Event FIFO: writes are refused when full, reads when empty; flags are registered
// so "full" is stable from the start of each cycle.
module stamp_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;
  logic wr_en, rd_en;

  assign wr_en  = push && !full;
  assign rd_en  = pop && !empty;
  assign wptr_n = wptr + (AW+1)'(wr_en);
  assign rptr_n = rptr + (AW+1)'(rd_en);
  assign dout   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      empty <= (wptr_n == rptr_n);
      full  <= (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/multi_stamper.sv
// Multi-channel trigger timestamper: per-channel holding registers feed a FIFO
// through a lowest-index arbiter; the host drains words over a serial shifter.
module multi_stamper
  import multi_stamper_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] trig,
  input  logic              dat_clk,
  input  logic              dat_ena,
  output logic              dat_out,
  output logic              dat_rdy,
  output logic [7:0]        drop_cnt
);
  localparam int CH_W    = calc_ch_w(NUM_CH);
  localparam int WORD_W  = calc_word_w(NUM_CH, CNT_WIDTH);
  localparam int CH_L    = ch_lsb(CNT_WIDTH);
  localparam int OVF_B   = ovf_bit(NUM_CH, CNT_WIDTH);
  localparam int VALID_B = valid_bit(NUM_CH, CNT_WIDTH);
  localparam int IN_W    = NUM_CH + 2;

  logic [IN_W-1:0] in_s1, in_s2, in_prev;
  logic [2:0] settle;
  logic armed, ena_rise, dclk_fall;
  logic [NUM_CH-1:0] evt, drop, grant, pend;
  logic [CNT_WIDTH-1:0] cnt, gnt_ts;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] hold_ts;
  logic [CH_W-1:0] gnt_id;
  logic ovf, push, pop, fifo_full, fifo_empty;
  logic [WORD_W-1:0] push_word, head_word, sr;
  logic [3:0] n_drop;
  logic [8:0] drop_sum;

  // Bus layout: {dat_clk, dat_ena, trig}
  always_ff @(posedge clk) begin
    if (rst) begin
      in_s1   <= '0;
      in_s2   <= '0;
      in_prev <= '0;
      settle  <= '0;
    end else begin
      in_s1   <= {dat_clk, dat_ena, trig};
      in_s2   <= in_s1;
      in_prev <= in_s2;
      settle  <= {settle[1:0], 1'b1};
    end
  end

  // Edges are ignored until in_prev holds real pin history, so a pin already
  // high when reset drops is not mistaken for a rising edge.
  assign armed     = settle[2];
  assign evt       = {NUM_CH{armed}} & in_s2[NUM_CH-1:0] & ~in_prev[NUM_CH-1:0];
  assign ena_rise  = armed & in_s2[NUM_CH] & ~in_prev[NUM_CH];
  assign dclk_fall = armed & ~in_s2[NUM_CH+1] & in_prev[NUM_CH+1];

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 1'b1;
  end

  // Descending scan so the lowest pending index wins.
  always_comb begin
    gnt_id = '0;
    gnt_ts = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (pend[i]) begin
        gnt_id = CH_W'(i);
        gnt_ts = hold_ts[i];
      end
    end
  end

  assign push = (|pend) && !fifo_full;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) grant[i] = push && (gnt_id == CH_W'(i));
  end

  // A new event on a channel already pending is lost, even if that channel is
  // being granted this same cycle.
  assign drop = evt & pend;

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < NUM_CH; i++) n_drop = n_drop + 4'(drop[i]);
  end

  assign drop_sum = {1'b0, drop_cnt} + {5'b0, n_drop};

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      hold_ts  <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!pend[i] && evt[i]) begin
          pend[i]    <= 1'b1;
          hold_ts[i] <= cnt;
        end else if (grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
      ovf      <= (|drop) | (ovf & ~push);
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  always_comb begin
    push_word                     = '0;
    push_word[VALID_B]            = 1'b1;
    push_word[OVF_B]              = ovf;
    push_word[CH_L +: CH_W]       = gnt_id;
    push_word[TS_LSB +: CNT_WIDTH] = gnt_ts;
  end

  stamp_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_word),
    .dout  (head_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop = ena_rise && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst)            sr <= '0;
    else if (ena_rise)  sr <= fifo_empty ? '0 : head_word;
    else if (dclk_fall) sr <= {sr[WORD_W-2:0], 1'b0};
  end

  assign dat_out = sr[WORD_W-1];
  assign dat_rdy = !fifo_empty;
endmodule

// File: tb/tb_multi_stamper.sv
// Bench for multi_stamper: a default-width instance checked against a queue model,
// plus an 8-bit-counter instance for timestamp wrap.
module tb_multi_stamper;
  localparam int NCH   = 4;
  localparam int CW0   = 24;
  localparam int CW1   = 8;
  localparam int WW0   = 28;
  localparam int WW1   = 12;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] trg0 = '0, trg1 = '0;
  logic dclk0 = 1'b0, dclk1 = 1'b0, ena0 = 1'b0, ena1 = 1'b0;
  logic dout0, dout1, rdy0, rdy1;
  logic [7:0] drop0, drop1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  multi_stamper #(.NUM_CH(NCH), .CNT_WIDTH(CW0), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .trig(trg0), .dat_clk(dclk0), .dat_ena(ena0),
    .dat_out(dout0), .dat_rdy(rdy0), .drop_cnt(drop0)
  );

  multi_stamper #(.NUM_CH(NCH), .CNT_WIDTH(CW1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .trig(trg1), .dat_clk(dclk1), .dat_ena(ena1),
    .dat_out(dout1), .dat_rdy(rdy1), .drop_cnt(drop1)
  );

  // Reference model of dut0: FIFO contents, per-channel pending entries, ovf, drops.
  logic [WW0-1:0] expq[$];
  bit [NCH-1:0] mpend;
  logic [NCH-1:0][CW0-1:0] mts;
  bit movf;
  int mdrops;

  function automatic void model_event(input int c, input logic [CW0-1:0] ts);
    if (mpend[c]) begin
      mdrops++;
      movf = 1'b1;
    end else if (expq.size() < DEPTH) begin
      expq.push_back({1'b1, movf, 2'(c), ts});
      movf = 1'b0;
    end else begin
      mpend[c] = 1'b1;
      mts[c]   = ts;
    end
  endfunction

  function automatic logic [WW0-1:0] model_pop();
    logic [WW0-1:0] w;
    w = '0;
    if (expq.size() > 0) w = expq.pop_front();
    for (int i = 0; i < NCH; i++) begin
      if (mpend[i] && expq.size() < DEPTH) begin
        expq.push_back({1'b1, movf, 2'(i), mts[i]});
        movf     = 1'b0;
        mpend[i] = 1'b0;
      end
    end
    return w;
  endfunction

  function automatic int sat_drops();
    return (mdrops > 255) ? 255 : mdrops;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Pulse trig bits of dut0 for 3 cycles; the timestamp is the count at sampling + 2.
  task automatic fire(input logic [NCH-1:0] mask);
    logic [CW0-1:0] ts;
    ts = CW0'(cyc + 2);
    trg0 = trg0 | mask;
    for (int c = 0; c < NCH; c++) if (mask[c]) model_event(c, ts);
    repeat (3) @(negedge clk);
    trg0 = trg0 & ~mask;
    repeat (4) @(negedge clk);
  endtask

  task automatic read_word(input int d, input int nb, output logic [WW0-1:0] w);
    w = '0;
    if (d == 0) ena0 = 1'b1; else ena1 = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      w = {w[WW0-2:0], (d == 0) ? dout0 : dout1};
      if (d == 0) dclk0 = 1'b1; else dclk1 = 1'b1;
      repeat (3) @(negedge clk);
      if (d == 0) dclk0 = 1'b0; else dclk1 = 1'b0;
      repeat (4) @(negedge clk);
    end
    if (d == 0) ena0 = 1'b0; else ena1 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [WW0-1:0] w;
    int perm[NCH];
    int j, t;

    // Reset with a trigger already high
    trg0[1] = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_dout", {31'b0, dout0}, 0);
    chk("rst_rdy", {31'b0, rdy0}, 0);
    chk("rst_drop", {24'b0, drop0}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    trg0[1] = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_trig_no_event", {31'b0, rdy0}, 0);

    // Single event sampled at count 100
    while (cyc != 100) @(negedge clk);
    fire(4'b0100);
    chk("single_rdy", {31'b0, rdy0}, 1);
    read_word(0, WW0, w);
    chk("single_word", w, 32'h0A000066);
    void'(model_pop());
    chk("single_rdy_after_pop", {31'b0, rdy0}, 0);

    // Empty read
    read_word(0, WW0, w);
    chk("empty_word", w, 0);
    chk("empty_rdy", {31'b0, rdy0}, 0);

    // Simultaneous events on channels 0 and 3
    fire(4'b1001);
    for (int k = 0; k < 2; k++) begin
      read_word(0, WW0, w);
      chk("simul_word", w, model_pop());
    end

    // Pile-up: 8 fill the FIFO, 4 more wait pending in random order
    for (int k = 0; k < DEPTH; k++) begin
      fire(4'(1 << $urandom_range(0, NCH-1)));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    for (int i = 0; i < NCH; i++) perm[i] = i;
    for (int i = NCH-1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < NCH; i++) fire(4'(1 << perm[i]));
    repeat (4) @(negedge clk);
    chk("pile_rdy", {31'b0, rdy0}, 1);
    chk("pile_nodrop", {24'b0, drop0}, 0);
    for (int k = 0; k < DEPTH + NCH; k++) begin
      read_word(0, WW0, w);
      chk("pile_word", w, model_pop());
    end
    chk("pile_drained", {31'b0, rdy0}, 0);

    // Drop on channel 1 while it waits behind a full FIFO
    for (int k = 0; k < DEPTH; k++) fire(4'(1 << $urandom_range(0, NCH-1)));
    fire(4'b0010);
    fire(4'b0010);
    fire(4'b0100);
    chk("drop_cnt_one", {24'b0, drop0}, 1);
    for (int k = 0; k < DEPTH + 2; k++) begin
      read_word(0, WW0, w);
      chk("drop_word", w, model_pop());
      if (k == DEPTH)     chk("drop_ovf_set", {31'b0, w[26]}, 1);
      if (k == DEPTH + 1) chk("drop_ovf_clear", {31'b0, w[26]}, 0);
    end

    // Random mix of events and reads
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) < 2) begin
        fire(4'(1 << $urandom_range(0, NCH-1)));
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end else begin
        read_word(0, WW0, w);
        chk("rand_word", w, model_pop());
      end
    end
    chk("rand_drops", {24'b0, drop0}, 32'(sat_drops()));
    while (expq.size() > 0) begin
      read_word(0, WW0, w);
      chk("rand_drain", w, model_pop());
    end
    chk("rand_drained_rdy", {31'b0, rdy0}, 0);

    // Counter wrap on the 8-bit instance: timestamps 255 then 0
    while ((cyc & 255) != 253) @(negedge clk);
    trg1[0] = 1'b1;
    @(negedge clk);
    trg1[1] = 1'b1;
    repeat (3) @(negedge clk);
    trg1 = '0;
    repeat (5) @(negedge clk);
    chk("wrap_rdy", {31'b0, rdy1}, 1);
    read_word(1, WW1, w);
    chk("wrap_ts255", w, 32'h8FF);
    read_word(1, WW1, w);
    chk("wrap_ts0", w, 32'h900);
    chk("wrap_rdy_after", {31'b0, rdy1}, 0);

    // Reset in the middle of a transfer
    fire(4'b0010);
    fire(4'b0001);
    ena0 = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      dclk0 = 1'b1;
      repeat (3) @(negedge clk);
      dclk0 = 1'b0;
      repeat (4) @(negedge clk);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_dout", {31'b0, dout0}, 0);
    chk("midrst_rdy", {31'b0, rdy0}, 0);
    chk("midrst_drop", {24'b0, drop0}, 0);
    rst = 1'b0;
    expq.delete();
    mpend  = '0;
    movf   = 1'b0;
    mdrops = 0;
    repeat (6) @(negedge clk);
    ena0 = 1'b0;
    repeat (6) @(negedge clk);
    chk("postrst_rdy", {31'b0, rdy0}, 0);
    chk("postrst_dout", {31'b0, dout0}, 0);
    read_word(0, WW0, w);
    chk("postrst_empty_word", w, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
